// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// 4x4 keypad scanner: sync, column scan, debounce, ASCII encode, FIFO; one key per press.
// Push to key_valid is 2 cycles; no new strobe until lcd_ready is seen low; a full FIFO drops keys.
module keypad_scanner #(
  parameter int SETTLE_CYC   = 8,
  parameter int DEBOUNCE_CYC = 10000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  input  logic       lcd_ready,
  output logic [7:0] data,
  output logic       key_valid,
  output logic       key_overflow,
  output logic [2:0] fifo_count
);
  localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] DB_END     = CW'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]    FULL_CNT   = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} scan_t;
  typedef enum logic {IDLE, WAIT_BUSY} hs_t;

  logic [3:0]    sync1, rs_n;
  scan_t         scan_state, scan_next;
  logic [1:0]    col, col_next, row, row_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          armed, push, push_ok, pop;
  logic [7:0]    key_code;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [2:0]    count;
  hs_t           hs_state, hs_next;

  function automatic logic [7:0] key_ascii(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_ascii = "1";
      4'h1: key_ascii = "2";
      4'h2: key_ascii = "3";
      4'h3: key_ascii = "A";
      4'h4: key_ascii = "4";
      4'h5: key_ascii = "5";
      4'h6: key_ascii = "6";
      4'h7: key_ascii = "B";
      4'h8: key_ascii = "7";
      4'h9: key_ascii = "8";
      4'hA: key_ascii = "9";
      4'hB: key_ascii = "C";
      4'hC: key_ascii = "*";
      4'hD: key_ascii = "0";
      4'hE: key_ascii = "#";
      default: key_ascii = "D";
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'hF;
      rs_n  <= 4'hF;
    end else begin
      sync1 <= row_n;
      rs_n  <= sync1;
    end
  end

  // armed holds the columns released for the first cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_state <= SCAN;
      col        <= 2'd0;
      row        <= 2'd0;
      cnt        <= '0;
      armed      <= 1'b0;
    end else begin
      scan_state <= scan_next;
      col        <= col_next;
      row        <= row_next;
      cnt        <= cnt_next;
      armed      <= 1'b1;
    end
  end

  assign col_n = armed ? ~(4'b0001 << col) : 4'b1111;

  always_comb begin
    scan_next = scan_state;
    col_next  = col;
    row_next  = row;
    cnt_next  = cnt;
    push      = 1'b0;
    if (armed) begin
      unique case (scan_state)
        SCAN: begin
          if (cnt != SETTLE_END) begin
            cnt_next = cnt + CW'(1);
          end else begin
            cnt_next = '0;
            if (rs_n != 4'hF) begin
              scan_next = PRESS_DB;
              if (!rs_n[0])      row_next = 2'd0;
              else if (!rs_n[1]) row_next = 2'd1;
              else if (!rs_n[2]) row_next = 2'd2;
              else               row_next = 2'd3;
            end else begin
              col_next = col + 2'd1;
            end
          end
        end
        PRESS_DB: begin
          if (rs_n[row]) begin
            scan_next = SCAN;
            col_next  = col + 2'd1;
            cnt_next  = '0;
          end else if (cnt == DB_END) begin
            push      = 1'b1;
            scan_next = HELD;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        HELD: begin
          cnt_next = '0;
          if (rs_n == 4'hF) scan_next = REL_DB;
        end
        REL_DB: begin
          if (rs_n != 4'hF) begin
            cnt_next = '0;
          end else if (cnt == DB_END) begin
            scan_next = SCAN;
            col_next  = col + 2'd1;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign key_code = key_ascii(row, col);

  always_comb begin
    hs_next = hs_state;
    pop     = 1'b0;
    unique case (hs_state)
      IDLE: begin
        if ((count != 3'd0) && lcd_ready) begin
          pop     = 1'b1;
          hs_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!lcd_ready) hs_next = IDLE;
      end
    endcase
  end

  // A simultaneous pop frees the slot, so a full FIFO still accepts that push
  assign push_ok = push && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_state     <= IDLE;
      key_valid    <= 1'b0;
      key_overflow <= 1'b0;
      data         <= 8'h00;
      wptr         <= '0;
      rptr         <= '0;
      count        <= 3'd0;
    end else begin
      hs_state     <= hs_next;
      key_valid    <= pop;
      key_overflow <= push && !push_ok;
      if (pop) begin
        data <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      if (push_ok) wptr <= wptr + AW'(1);
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wptr] <= key_code;
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Directed bench: keypad matrix model, LCD acknowledge model, and a scoreboard of
// expected ASCII strobes filled from the keys each scenario presses long enough.
module tb_keypad_scanner;
  localparam int S = 8;
  localparam int D = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n, col_n;
  logic       lcd_ready = 1'b0;
  logic [7:0] data;
  logic       key_valid, key_overflow;
  logic [2:0] fifo_count;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;
  int         lcd_mode = 0;
  int         checks = 0, errors = 0;
  int         n_strobe = 0, n_ovf = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] exp_q[$];
  bit         seen_low = 1'b1;
  bit         prev_kv = 1'b0;
  string      keys = "123A456B789C*0#D";

  keypad_scanner #(.SETTLE_CYC(S), .DEBOUNCE_CYC(D), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .lcd_ready(lcd_ready),
    .data(data), .key_valid(key_valid), .key_overflow(key_overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row to its column only while that column is driven low
  always_comb begin
    row_n = 4'hF;
    if (key_down && !col_n[key_c]) row_n[key_r] = 1'b0;
  end

  // LCD model: 0 = busy, 1 = drops ready for one cycle after each strobe, 2 = ready
  always @(posedge clk) begin
    #1;
    case (lcd_mode)
      1:       lcd_ready = !key_valid;
      2:       lcd_ready = 1'b1;
      default: lcd_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen_low  = 1'b1;
      prev_kv   = 1'b0;
      last_data = 8'h00;
    end else begin
      check("col_at_most_one_low", 32'($countones(~col_n) <= 1), 1);
      check("fifo_count_bound", 32'(fifo_count <= 3'd4), 1);
      if (key_overflow) n_ovf++;
      if (key_valid) begin
        n_strobe++;
        check("strobe_one_cycle", 32'(prev_kv), 0);
        check("ready_low_before_strobe", 32'(seen_low), 1);
        seen_low = !lcd_ready;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got data %02h expected no strobe", data);
        end else begin
          check("strobe_data", 32'(data), 32'(exp_q.pop_front()));
        end
        last_data = data;
      end else begin
        if (!lcd_ready) seen_low = 1'b1;
        check("data_holds", 32'(data), 32'(last_data));
      end
      prev_kv = key_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] ascii_of(input int r, input int c);
    return keys[r * 4 + c];
  endfunction

  task automatic press(input int r, input int c, input int hold, input int rel);
    key_r = 2'(r);
    key_c = 2'(c);
    key_down = 1'b1;
    tick(hold);
    key_down = 1'b0;
    tick(rel);
  endtask

  // Returns at the first sample where col_n switches to target
  task automatic wait_col(input logic [3:0] target);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = col_n;
    for (int i = 0; i < 80 && !found; i++) begin
      tick(1);
      if (col_n == target && prev != target) found = 1'b1;
      prev = col_n;
    end
    check("col_transition_found", 32'(found), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, ovf0;
    logic [3:0] e;

    // Reset state, then the free-running column scan
    tick(3);
    check("rst_col_n", 32'(col_n), 32'h0000_000F);
    check("rst_data", 32'(data), 0);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_overflow", 32'(key_overflow), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    rst = 1'b0;
    tick(1);
    for (int k = 0; k < 8; k++) begin
      e = 4'b1111;
      e[k % 4] = 1'b0;
      check("scan_col_first", 32'(col_n), 32'(e));
      tick(S);
      check("scan_col_last", 32'(col_n), 32'(e));
      tick(1);
    end
    check("idle_fifo_count", 32'(fifo_count), 0);
    check("idle_no_strobe", n_strobe, 0);

    // Clean "6" held long, LCD acknowledging
    lcd_mode = 1;
    s0 = n_strobe;
    exp_q.push_back(ascii_of(1, 2));
    press(1, 2, 3 * D + 60, 0);
    check("six_one_strobe", n_strobe - s0, 1);
    check("six_literal", 32'(last_data), 32'h36);
    check("six_held_col", 32'(col_n), 32'b1011);
    tick(D + 2);
    check("release_debounce_holds_col", 32'(col_n), 32'b1011);
    tick(1);
    check("release_next_col", 32'(col_n), 32'b0111);
    tick(20);

    // Bouncing "1": one strobe; then a short press gives nothing
    s0 = n_strobe;
    exp_q.push_back(ascii_of(0, 0));
    key_r = 2'd0;
    key_c = 2'd0;
    for (int i = 0; i < 5; i++) begin
      key_down = 1'b1;
      tick(4);
      key_down = 1'b0;
      tick(4);
    end
    press(0, 0, 3 * D + 60, D + 20);
    check("bounce_one_strobe", n_strobe - s0, 1);
    check("bounce_literal", 32'(last_data), 32'h31);
    s0 = n_strobe;
    wait_col(4'b1110);
    press(0, 0, D / 2, D + 20);
    check("short_press_no_strobe", n_strobe - s0, 0);
    check("short_press_fifo", 32'(fifo_count), 0);

    // LCD busy: fill to 4, fifth key overflows, then drain in order
    lcd_mode = 0;
    tick(2);
    ovf0 = n_ovf;
    s0 = n_strobe;
    for (int i = 0; i < 5; i++) begin
      int r, c;
      r = (i < 3) ? 0 : 1;
      c = (i < 3) ? i : i - 3;
      if (i < 4) exp_q.push_back(ascii_of(r, c));
      press(r, c, 120, D + 20);
      check("fill_fifo_count", 32'(fifo_count), (i < 4) ? i + 1 : 4);
    end
    check("overflow_once", n_ovf - ovf0, 1);
    lcd_mode = 1;
    tick(20);
    check("drain_fifo_empty", 32'(fifo_count), 0);
    check("drain_strobes", n_strobe - s0, 4);
    check("drain_last_literal", 32'(last_data), 32'h34);

    // Push lands in the same cycle as a pop of a full FIFO
    lcd_mode = 0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ascii_of(i, 3));
      press(i, 3, 120, D + 20);
    end
    check("full_before", 32'(fifo_count), 4);
    ovf0 = n_ovf;
    wait_col(4'b1110);
    key_r = 2'd0;
    key_c = 2'd0;
    key_down = 1'b1;
    exp_q.push_back(ascii_of(0, 0));
    tick(7 + D);
    check("full_pre_pop", 32'(fifo_count), 4);
    lcd_mode = 2;
    tick(1);
    lcd_mode = 0;
    check("full_ready_window", 32'(fifo_count), 4);
    tick(1);
    check("coincide_strobe", 32'(key_valid), 1);
    check("coincide_count", 32'(fifo_count), 4);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("coincide_count_after", 32'(fifo_count), 4);
    end
    check("coincide_no_overflow", n_ovf - ovf0, 0);
    key_down = 1'b0;
    tick(D + 20);
    lcd_mode = 1;
    tick(20);
    check("coincide_drained", 32'(fifo_count), 0);

    // Reset while "D" is being debounced
    wait_col(4'b0111);
    key_r = 2'd3;
    key_c = 2'd3;
    key_down = 1'b1;
    tick(S + 16);
    rst = 1'b1;
    tick(1);
    check("midrst_col_n", 32'(col_n), 32'h0000_000F);
    check("midrst_key_valid", 32'(key_valid), 0);
    check("midrst_fifo", 32'(fifo_count), 0);
    key_down = 1'b0;
    tick(2);
    rst = 1'b0;
    s0 = n_strobe;
    tick(1);
    check("restart_col0", 32'(col_n), 32'b1110);
    tick(3 * D);
    check("midrst_no_strobe", n_strobe - s0, 0);
    check("midrst_fifo_after", 32'(fifo_count), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronises and debounces key presses, and encodes each press to ASCII.
- Buffers encoded keys in a small FIFO.
- Feeds the LCD character stage over its data/key_valid/lcd_ready handshake: one ASCII byte per press, no repeats while a key is held.
- Sits directly upstream of the LCD writer and runs on the same 1 MHz clock.

Parameters:
- SETTLE_CYC, 8: cycles a column is driven low before its rows are sampled.
- DEBOUNCE_CYC, 10000: consecutive stable cycles needed to accept a press or a release (10 ms at 1 MHz).
- FIFO_DEPTH, 4: keys buffered; power of two, minimum 2.

Ports:
- clk  in  1  system clock, 1 MHz.
- rst  in  1  reset.
- row_n  in  4  keypad rows, active-low, externally pulled up, asynchronous.
- col_n  out  4  keypad column drive, exactly one bit low while scanning.
- lcd_ready  in  1  LCD stage is idle and will latch data on key_valid.
- data  out  8  ASCII code of the key being offered.
- key_valid  out  1  one-cycle strobe; data is valid in the same cycle.
- key_overflow  out  1  one-cycle pulse when a debounced key is dropped because the FIFO is full.
- fifo_count  out  3  number of keys buffered, 0..FIFO_DEPTH.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port clk, reset port rst.
- Reset values: col_n=4'b1111, data=8'h00, key_valid=0, key_overflow=0, fifo_count=0. Scan FSM resets to SCAN with column 0. FIFO pointers are cleared. The 2-flop row synchroniser resets to 4'b1111.
- Reset mid-operation: any press in progress is discarded. After rst falls, scanning resumes from column 0 on the next clock.
- row_n passes through a 2-flop synchroniser. All decisions use the synchronised value rs_n.
- Key map, row r / column c, r and c = 0..3:
  - r0: "1" "2" "3" "A"
  - r1: "4" "5" "6" "B"
  - r2: "7" "8" "9" "C"
  - r3: "*" "0" "#" "D"
- Scan FSM:
  - SCAN: drive col_n with only bit col low and count SETTLE_CYC cycles, then sample rs_n.
    - If any bit is low, latch the lowest-index low row and go to PRESS_DB.
    - Otherwise col advances (3 wraps to 0) and the settle count restarts.
  - PRESS_DB: hold the column and count cycles while the latched row stays low.
    - If the row goes high before DEBOUNCE_CYC, return to SCAN on the next column; nothing is pushed.
    - At DEBOUNCE_CYC, push the code and go to HELD.
  - HELD: hold the column. When rs_n==4'b1111, go to REL_DB.
  - REL_DB: count consecutive all-high cycles; any low bit restarts the count.
    - At DEBOUNCE_CYC, return to SCAN on the next column.
  - A key held indefinitely yields exactly one push. A second key pressed while one is held is ignored.
- FIFO:
  - Push is rejected when count==FIFO_DEPTH and there is no pop that cycle. The rejected key is dropped and key_overflow pulses for 1 cycle.
  - Push and pop in the same cycle with count==FIFO_DEPTH: both succeed.
  - Push and pop in the same cycle at any count: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output handshake FSM:
  - IDLE: if fifo_count>0 and lcd_ready==1, on the next edge assert key_valid for exactly 1 cycle, drive data=FIFO head, pop the FIFO, then go to WAIT_BUSY.
  - WAIT_BUSY: key_valid=0. Wait until lcd_ready==0 is sampled, then go to IDLE.
  - No second strobe is issued before lcd_ready has been seen low.
  - data holds its last value between strobes.
- Latency: from the first debounced-stable cycle to push is DEBOUNCE_CYC cycles. From push into an empty FIFO with lcd_ready=1 to key_valid is 2 cycles.

Test Plan:
- Reset, no keys -> col_n cycles 1110,1101,1011,0111 every SETTLE_CYC+1 cycles; key_valid never asserts; fifo_count=0.
- Press r1/c2 clean for 20 ms with lcd_ready=1 -> exactly one key_valid with data=8'h36 ("6"); after lcd_ready drops, no repeat while held; after release plus 10 ms, scanning resumes.
- Bounce on r0/c0: 5 low/high toggles of 100 us, then stable low -> exactly one key_valid with data=8'h31; a 5 ms press produces no strobe.
- lcd_ready=0, press "1","2","3","4","5" -> fifo_count reaches 4; key_overflow pulses once on "5"; raising lcd_ready, toggled low 1 cycle after each strobe, yields data 31,32,33,34 in order, then fifo_count=0.
- Push coincides with pop while the FIFO is full -> no overflow pulse; fifo_count stays 4.
- Assert rst during PRESS_DB of "D" -> no strobe; col_n=1111 during reset; scan restarts at column 0 the cycle after release.
